// File: rtl/barrel_shifter_pipe_r.sv
// rtl/barrel_shifter_pipe_r.sv - pipelined rotate-right barrel shifter with valid/ready handshake
//
// Purpose:
//   Rotates a right by amt, one registered stage per amount bit. Stage k
//   applies the 2^k rotation when bit k of the amount is set. All stages
//   advance together under one enable, so a stalled output freezes the
//   whole pipe. This is the inverse of the rotate-left shifter: feeding
//   rotl(a, amt) through this block with the same amt returns a.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   a / amt are valid this cycle
//   in_ready   block accepts input this cycle (depends only on out_ready and pipe state)
//   a          word to rotate, N bits
//   amt        rotate-right amount, M bits
//   out_valid  y is valid
//   out_ready  downstream accepts y this cycle
//   y          a rotated right by amt, N bits

module barrel_shifter_pipe_r #(
  parameter int N = 8,
  parameter int M = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [M-1:0] amt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y
);

  // Per-stage state: valid flag, partially rotated word, amount bits.
  logic         vld_q   [M];
  logic [N-1:0] d_q     [M];
  logic [M-1:0] amt_q   [M];

  logic         vld_nxt [M];
  logic [N-1:0] d_nxt   [M];
  logic [M-1:0] amt_nxt [M];

  logic         en;

  // The last stage's amount bits have all been consumed by then.
  logic         unused_tail_amt;

  function automatic logic [N-1:0] rotr(input logic [N-1:0] x, input int s);
    return (x >> s) | (x << (N - s));
  endfunction

  // Single global advance: a full output slot that is not being taken
  // blocks everything, otherwise every stage shifts forward (bubbles too).
  assign en        = ~vld_q[M-1] | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[M-1];
  assign y         = d_q[M-1];

  assign unused_tail_amt = ^amt_q[M-1];

  always_comb begin
    for (int k = 0; k < M; k++) begin
      vld_nxt[k] = 1'b0;
      d_nxt[k]   = '0;
      amt_nxt[k] = '0;
    end

    // Bubbles entering stage 0 carry zeros so invalid slots stay
    // deterministic regardless of what sits on a / amt.
    vld_nxt[0] = in_valid;
    if (in_valid) begin
      d_nxt[0]   = amt[0] ? {a[0], a[N-1:1]} : a;
      amt_nxt[0] = amt;
    end

    for (int k = 1; k < M; k++) begin
      vld_nxt[k] = vld_q[k-1];
      d_nxt[k]   = amt_q[k-1][k] ? rotr(d_q[k-1], 1 << k) : d_q[k-1];
      amt_nxt[k] = amt_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < M; k++) begin
        vld_q[k] <= 1'b0;
        d_q[k]   <= '0;
        amt_q[k] <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < M; k++) begin
        vld_q[k] <= vld_nxt[k];
        d_q[k]   <= d_nxt[k];
        amt_q[k] <= amt_nxt[k];
      end
    end
  end

endmodule

// File: tb/tb_barrel_shifter_pipe_r.sv
// tb/tb_barrel_shifter_pipe_r.sv - self-checking bench for barrel_shifter_pipe_r

module tb_barrel_shifter_pipe_r;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  // Default build N=8, M=3
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, y;
  logic [2:0] amt;

  // Sweep build N=16, M=4
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, y16;
  logic [3:0]  amt16;

  // Sweep build N=4, M=2
  logic       in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0] a4, y4;
  logic [1:0] amt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  barrel_shifter_pipe_r #(.N(8), .M(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .amt(amt),
    .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  barrel_shifter_pipe_r #(.N(16), .M(4)) dut16 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .amt(amt16),
    .out_valid(out_valid16), .out_ready(out_ready16), .y(y16)
  );

  barrel_shifter_pipe_r #(.N(4), .M(2)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .amt(amt4),
    .out_valid(out_valid4), .out_ready(out_ready4), .y(y4)
  );

  typedef struct {
    logic [7:0] a;
    logic [2:0] amt;
    logic [7:0] exp_y;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
    return (x << s) | (x >> (8 - s));
  endfunction

  initial begin
    logic [7:0] sb [$];
    logic [7:0] ra;
    logic [2:0] ramt;
    int sent, got, cyc;

    vecs[0] = '{8'h81, 3'd1, 8'hC0};
    vecs[1] = '{8'h01, 3'd3, 8'h20};
    vecs[2] = '{8'h01, 3'd7, 8'h02};
    vecs[3] = '{8'hA5, 3'd0, 8'hA5};
    vecs[4] = '{8'h3C, 3'd4, 8'hC3};
    vecs[5] = '{8'h96, 3'd5, 8'hB4};

    in_valid = 0; a = 0; amt = 0; out_ready = 1;
    in_valid16 = 0; a16 = 0; amt16 = 0; out_ready16 = 1;
    in_valid4 = 0; a4 = 0; amt4 = 0; out_ready4 = 1;

    // Reset
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset y", y, 0);
    check("reset in_ready", in_ready, 1);

    // Basic rotates, exact latency of 3 cycles
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; a = vecs[i].a; amt = vecs[i].amt;
      step();
      in_valid = 0; a = 8'hFF; amt = 3'd5;
      step();
      check($sformatf("vec%0d early out_valid", i), out_valid, 0);
      step();
      check($sformatf("vec%0d out_valid", i), out_valid, 1);
      check($sformatf("vec%0d y", i), y, vecs[i].exp_y);
      step();
      check($sformatf("vec%0d drained", i), out_valid, 0);
    end

    // Streaming 8 back-to-back words
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        in_valid = 1; a = 8'h80; amt = 3'(c);
        check($sformatf("stream in_ready c%0d", c), in_ready, 1);
      end else begin
        in_valid = 0;
      end
      step();
      if (c + 1 >= 3 && c + 1 - 3 < 8) begin
        check($sformatf("stream out_valid c%0d", c + 1), out_valid, 1);
        check($sformatf("stream y c%0d", c + 1), y, 8'h80 >> (c + 1 - 3));
      end else begin
        check($sformatf("stream idle c%0d", c + 1), out_valid, 0);
      end
    end

    // Backpressure
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1; a = 8'hF0; amt = 3'(i);
      step();
    end
    in_valid = 0;
    out_ready = 0;
    #1;
    check("bp first out_valid", out_valid, 1);
    check("bp first y", y, 8'h78);
    check("bp in_ready low", in_ready, 0);
    for (int s = 0; s < 5; s++) begin
      in_valid = 1; a = 8'hFF; amt = 3'd5;  // must be ignored
      step();
      check($sformatf("bp stall%0d out_valid", s), out_valid, 1);
      check($sformatf("bp stall%0d y", s), y, 8'h78);
      check($sformatf("bp stall%0d in_ready", s), in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    #1;
    check("bp rel0 y", y, 8'h78);
    step();
    check("bp rel1 valid", out_valid, 1);
    check("bp rel1 y", y, 8'h3C);
    step();
    check("bp rel2 valid", out_valid, 1);
    check("bp rel2 y", y, 8'h1E);
    step();
    check("bp no duplicate", out_valid, 0);

    // Reset mid-operation
    in_valid = 1; a = 8'h55; amt = 3'd2;
    step();
    a = 8'hAA; amt = 3'd3;
    step();
    in_valid = 0;
    #1 reset_n = 1'b0;
    #1;
    check("midreset out_valid", out_valid, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    #1;
    check("midreset in_ready", in_ready, 1);
    for (int s = 0; s < 4; s++) begin
      step();
      check($sformatf("midreset no stale %0d", s), out_valid, 0);
    end
    in_valid = 1; a = 8'h03; amt = 3'd1;
    step();
    in_valid = 0;
    step();
    step();
    check("post reset out_valid", out_valid, 1);
    check("post reset y", y, 8'h81);
    step();

    // Round-trip through a rotate-left model with random backpressure
    sent = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      if (sent < 1000 && $urandom_range(0, 3) != 0) begin
        ra = 8'($urandom);
        ramt = 3'($urandom);
        in_valid = 1; a = rotl8(ra, int'(ramt)); amt = ramt;
      end else begin
        in_valid = 0; ra = 0; a = 0; amt = 0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("roundtrip spurious word", 1, 0);
        end else begin
          check($sformatf("roundtrip word%0d", got), y, sb.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(ra);
        sent++;
      end
      step();
      cyc++;
    end
    in_valid = 0; out_ready = 1;
    check("roundtrip count", got, 1000);
    check("roundtrip leftover", sb.size(), 0);
    repeat (4) step();

    // Parameter sweep builds
    in_valid16 = 1; a16 = 16'h0001; amt16 = 4'd15;
    in_valid4 = 1; a4 = 4'b0011; amt4 = 2'd1;
    step();
    in_valid16 = 0; in_valid4 = 0;
    check("n4 early out_valid", out_valid4, 0);
    step();
    check("n4 out_valid", out_valid4, 1);
    check("n4 y", y4, 4'b1001);
    step();
    check("n16 early out_valid", out_valid16, 0);
    step();
    check("n16 out_valid", out_valid16, 1);
    check("n16 y", y16, 16'h0002);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/barrel_shifter_pipe_r.md
Name: barrel_shifter_pipe_r

Overview:
- Pipelined rotate-right barrel shifter. It is the inverse-direction companion of the team's combinational multistage rotate-left shifter.
- One registered stage per amount bit. Stage k conditionally rotates right by 2^k.
- Valid/ready handshake on both sides, so it drops into streaming datapaths.
- Rotate-left by amt followed by this block with the same amt returns the original word. This round-trip property is the block's primary check.

Parameters:
- N, 8, data width in bits; must equal 2**M.
- M, 3, amount width and number of pipeline stages; legal range 1..5.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a, amt are valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- a  input  N  word to rotate.
- amt  input  M  rotate-right amount, 0..N-1.
- out_valid  output  1  y is valid.
- out_ready  input  1  downstream accepts y this cycle.
- y  output  N  a rotated right by amt.

Behaviour:
- Reset (reset_n low, asynchronous assert, synchronous-to-clk deassert at the system level):
  - All stage valid bits clear to 0; all stage data and amount registers clear to 0.
  - Outputs: out_valid=0, y=0, in_ready=1.
- Stage registers, k = 0..M-1, each holding vld_k, d_k, amt_k (amt_k carries the remaining amount bits):
  - Stage 0 captures: a rotated right by 1 if amt[0], else a. Written as a[0] concatenated above a[N-1:1].
  - Stage k (k≥1) captures: d_(k-1) rotated right by 2^k if amt_(k-1)[k], else d_(k-1).
  - y = d_(M-1); out_valid = vld_(M-1).
- Global advance enable: en = ~vld_(M-1) | out_ready.
  - When en=1, every stage loads from its predecessor; stage 0 loads from the inputs and sets vld_0 = in_valid.
  - When en=0, all stages hold.
  - in_ready = en. This is combinational from out_ready; no combinational path from in_valid to in_ready.
- Bubbles are not collapsed. An invalid stage advances like a valid one; its data content is don't-care but must be deterministic.
- Latency: M cycles from the accepting edge (in_valid & in_ready) to out_valid, with no stalls. Throughput: one word per cycle while out_ready=1.
- Stall: with out_valid=1 and out_ready=0, y, out_valid and all internal stages are frozen. in_ready=0. a/amt are ignored regardless of in_valid.
- Simultaneous accept and emit in the same cycle is legal and must not drop or duplicate words.
- amt=0 passes the word through unchanged after M cycles. amt ≥ N is impossible by width.
- Reset mid-stream: all in-flight words are discarded; out_valid=0 on the next sample after reset_n falls. No word accepted before reset may appear after it.
- Ordering: output order equals acceptance order.

Test Plan:
- Basic rotates, out_ready=1, each input a single word:
  - a=8'h81, amt=1 -> y=8'hC0 exactly 3 cycles after accept.
  - a=8'h01, amt=3 -> y=8'h20.
  - a=8'h01, amt=7 -> y=8'h02.
  - a=8'hA5, amt=0 -> y=8'hA5.
- Streaming: 8 back-to-back words a=8'h80, amt=0..7 with out_ready=1. Expect y=8'h80,40,20,10,08,04,02,01 on 8 consecutive cycles starting at cycle 3. in_ready stays 1 throughout.
- Backpressure: stream a=8'hF0, amt=1,2,3 and hold out_ready=0 for 5 cycles once out_valid rises. Expect:
  - y=8'h78 held stable and in_ready=0 during the stall.
  - After release: 8'h78, 8'h3C, 8'h1E, with none lost or duplicated.
- Reset mid-operation: accept 2 words, then pulse reset_n low for 1 cycle between clock edges. Expect out_valid=0 immediately and no stale word emitted afterwards. A new word a=8'h03, amt=1 then yields y=8'h81.
- Round-trip: drive 1000 random (a, amt) pairs through the team's rotate-left shifter into this block. Expect y == a for every word, in order, with random out_ready toggling.
- Parameter sweep: N=16, M=4 and N=4, M=2 builds.
  - a=16'h0001, amt=15 -> y=16'h0002.
  - a=4'b0011, amt=1 -> y=4'b1001.
